// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register (hold, shift right,
// shift left, parallel load) with a saturating shift counter, a full flag and
// a one-cycle done pulse when a complete word has been shifted since the last
// load or reset. Usable as a SIPO/PISO serialiser front-end.
//
// Optional feature, selected by defining UNIV_SHIFT_REG_ROTATE_EN:
//   rot_i=1 during a shift recirculates the outgoing bit instead of taking
//   the serial input. Without the macro rot_i is ignored.
module univ_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             si_r_i,
    input  logic             si_l_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             rot_i,
    output logic [WIDTH-1:0] q_o,
    output logic             so_r_o,
    output logic             so_l_o,
    output logic [CW-1:0]    cnt_o,
    output logic             full_o,
    output logic             done_o
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             in_r, in_l;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Select the bit entering each end: serial input, or the outgoing bit when rotating.
    always_comb begin
        in_r = rot_i ? q_q[0]       : si_r_i;
        in_l = rot_i ? q_q[WIDTH-1] : si_l_i;
    end
`else
    logic unused_rot;
    assign unused_rot = rot_i;

    // Without rotate support the serial inputs always feed the shift.
    always_comb begin
        in_r = si_r_i;
        in_l = si_l_i;
    end
`endif

    // Next-state for register contents, shift counter and done pulse.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_SHR: begin
                    q_d    = {in_r, q_q[WIDTH-1:1]};
                    cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
                    done_d = (cnt_q == CNT_LAST);
                end
                MODE_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], in_l};
                    cnt_d  = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
                    done_d = (cnt_q == CNT_LAST);
                end
                MODE_LOAD: begin
                    q_d   = d_i;
                    cnt_d = '0;
                end
                MODE_HOLD: begin
                    q_d = q_q;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q_o    = q_q;
    assign so_r_o = q_q[0];
    assign so_l_o = q_q[WIDTH-1];
    assign cnt_o  = cnt_q;
    assign full_o = (cnt_q == CNT_MAX);
    assign done_o = done_q;

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register, the successor to the 4-bit serial-in/serial-out register.
- Four modes: hold, shift right, shift left, parallel load.
- Provides a full parallel output and serial outputs at both ends.
- A shift counter flags when a full word has been shifted since the last load, so the block works as a SIPO/PISO serialiser front-end.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH+1), width of the shift counter; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- en  in  1  clock enable; 0 forces hold in all modes
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- si_r  in  1  serial in for shift right; enters q[WIDTH-1]
- si_l  in  1  serial in for shift left; enters q[0]
- d  in  WIDTH  parallel load data
- rot  in  1  rotate request; used only with ROTATE_EN
- q  out  WIDTH  register contents, registered
- so_r  out  1  q[0], the bit leaving on a right shift (combinational from q)
- so_l  out  1  q[WIDTH-1], the bit leaving on a left shift (combinational from q)
- cnt  out  CW  shifts since last load or reset, saturating at WIDTH, registered
- full  out  1  cnt == WIDTH (combinational from cnt)
- done  out  1  one-cycle pulse, registered

Behaviour:
- Reset (rst=0, asynchronous, any time, including mid-shift): q=0, cnt=0, done=0, so full=0. Released synchronously on the next clk edge after rst=1.
- All updates occur on posedge clk. Each update takes effect on the same edge; there is no extra output pipeline stage.
- en=0: q, cnt unchanged; done=0. This applies regardless of mode.
- en=1, mode 00: q, cnt hold; done=0.
- en=1, mode 01: q <= {si_r, q[WIDTH-1:1]}.
- en=1, mode 10: q <= {q[WIDTH-2:0], si_l}.
- en=1, mode 11: q <= d; cnt <= 0; done <= 0.
- Shift (mode 01 or 10 with en=1):
  - cnt <= (cnt==WIDTH) ? WIDTH : cnt+1.
  - done <= (cnt==WIDTH-1), i.e. a single pulse on the edge where cnt reaches WIDTH.
  - No re-pulse while saturated.
  - done is 0 on every non-shift cycle.
- Serial latency: a bit presented on si_l at shift edge k appears on so_l after edge k+WIDTH-1, i.e. WIDTH shift edges to traverse. Same for si_r to so_r. Hold cycles in between do not advance it.
- Direction change mid-word: allowed. cnt keeps counting total shifts, not net position.
- Load when full: clears cnt and full in the same edge.
- No illegal mode encodings exist.

Optional Feature:
- Macro: UNIV_SHIFT_REG_ROTATE_EN.
- Defined:
  - rot=1 during a shift substitutes the outgoing bit for the serial input: right shift takes q[0] into MSB; left shift takes q[WIDTH-1] into LSB.
  - si_r/si_l are ignored while rot=1.
  - cnt and done behave as for a normal shift.
  - rot has no effect in hold or load modes.
- Not defined: rot ignored entirely; behaviour identical to rot=0.

Test Plan:
- Reset: rst=0 asserted mid-cycle with q=0xFF, cnt=5 -> q=0x00, cnt=0, full=0, done=0 immediately, without waiting for a clk edge.
- PISO: en=1, mode=11, d=0xA5, one edge -> q=0xA5, cnt=0. Then mode=01, si_r=0, 8 edges:
  - so_r before each edge reads 1,0,1,0,0,1,0,1.
  - done=1 only after edge 8; q=0x00, cnt=8, full=1.
  - A 9th shift keeps cnt=8, done=0.
- SIPO: after reset, mode=10, si_l=1 for 3 edges -> q=0x01,0x03,0x07, cnt=3. Then en=0 for 2 edges with mode=10 -> q=0x07, cnt=3 unchanged.
- Hold/load priority: q=0x3C, cnt=8, mode=11, d=0x5A, en=1 -> q=0x5A, cnt=0, full=0. Same stimulus with en=0 -> q=0x3C, cnt=8.
- Rotate: load 0x81, then mode=10, rot=1, si_l=0, one edge:
  - With UNIV_SHIFT_REG_ROTATE_EN -> q=0x03.
  - Without -> q=0x02.
  - With the macro, 8 rotate shifts return q=0x81 and pulse done.
